// File: rtl/add_result_accumulator.sv
// add_result_accumulator: sums a programmed burst of adder results and counts carry-outs.
// Define ACC_SATURATE_EN to clamp the sum at all-ones instead of wrapping.
module add_result_accumulator #(
    parameter int WIDTH       = 32,
    parameter int ACC_WIDTH   = 64,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_len,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH:0]         i_result,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [ACC_WIDTH-1:0]   o_sum,
    output logic [COUNT_WIDTH-1:0] o_carry_cnt,
    output logic                   o_overflow,
    output logic                   o_busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state, state_n;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   accept;
    logic                   load;
    logic [ACC_WIDTH:0]     add_full;
    logic [ACC_WIDTH-1:0]   sum_n;

    assign accept   = (state == ACCUM) && i_valid;
    assign load     = (state == IDLE) && i_start;
    assign add_full = {1'b0, o_sum} + {{(ACC_WIDTH-WIDTH){1'b0}}, i_result};
`ifdef ACC_SATURATE_EN
    assign sum_n = add_full[ACC_WIDTH] ? '1 : add_full[ACC_WIDTH-1:0];
`else
    assign sum_n = add_full[ACC_WIDTH-1:0];
`endif
    // handshake flags decode straight from the state register
    assign o_ready = state == ACCUM;
    assign o_valid = state == HOLD;
    assign o_busy  = state != IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_start) state_n = (i_len != '0) ? ACCUM : HOLD;
            ACCUM:   if (accept && remaining == COUNT_WIDTH'(1)) state_n = HOLD;
            HOLD:    if (i_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            remaining   <= '0;
            o_sum       <= '0;
            o_carry_cnt <= '0;
            o_overflow  <= 1'b0;
        end else if (load) begin
            remaining   <= i_len;
            o_sum       <= '0;
            o_carry_cnt <= '0;
            o_overflow  <= 1'b0;
        end else if (accept) begin
            remaining   <= remaining - COUNT_WIDTH'(1);
            o_sum       <= sum_n;
            o_carry_cnt <= o_carry_cnt + {{(COUNT_WIDTH-1){1'b0}}, i_result[WIDTH]};
            o_overflow  <= o_overflow | add_full[ACC_WIDTH];
        end
    end
endmodule

// File: tb/tb_add_result_accumulator.sv
// tb_add_result_accumulator: directed bursts with a scoreboard of expected totals,
// plus a 33-bit accumulator instance for the overflow/saturation corner.
module tb_add_result_accumulator;
    typedef struct {
        logic [63:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        valid = 1'b0;
    logic        ready_o;
    logic [32:0] result = '0;
    logic        valid_o;
    logic        ready = 1'b0;
    logic [63:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
    logic        busy;

    logic        s_start = 1'b0;
    logic [7:0]  s_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready_o;
    logic [32:0] s_result = '0;
    logic        s_valid_o;
    logic        s_ready = 1'b0;
    logic [32:0] s_sum;
    logic [7:0]  s_cnt;
    logic        s_ovf;
    logic        s_busy;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [64:0] m_sum;
    logic [7:0]  m_cnt;
    logic        m_ovf;

    add_result_accumulator dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
        .i_valid(valid), .o_ready(ready_o), .i_result(result),
        .o_valid(valid_o), .i_ready(ready), .o_sum(sum),
        .o_carry_cnt(cnt), .o_overflow(ovf), .o_busy(busy)
    );

    add_result_accumulator #(.ACC_WIDTH(33)) dut33 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_len(s_len),
        .i_valid(s_valid), .o_ready(s_ready_o), .i_result(s_result),
        .o_valid(s_valid_o), .i_ready(s_ready), .o_sum(s_sum),
        .o_carry_cnt(s_cnt), .o_overflow(s_ovf), .o_busy(s_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_burst(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        m_sum = '0;
        m_cnt = '0;
        m_ovf = 1'b0;
        check("busy_after_start", 65'(busy), 65'd1);
        if (l != 0) check("ready_after_start", 65'(ready_o), 65'd1);
        else        check("valid_after_len0", 65'(valid_o), 65'd1);
    endtask

    task automatic feed(input logic [32:0] r);
        check("ready_before_accept", 65'(ready_o), 65'd1);
        valid  = 1'b1;
        result = r;
        m_sum  = {1'b0, m_sum[63:0]} + {32'd0, r};
        m_ovf  = m_ovf | m_sum[64];
        m_cnt  = m_cnt + {7'd0, r[32]};
        tick();
        valid  = 1'b0;
        result = 33'h1_DEAD_BEEF;
    endtask

    task automatic gap();
        tick();
        check("ready_during_gap", 65'(ready_o), 65'd1);
    endtask

    task automatic finish_burst();
        exp_t e;
        e.sum = m_sum[63:0];
        e.cnt = m_cnt;
        e.ovf = m_ovf;
        sb.push_back(e);
    endtask

    task automatic drain(input int hold);
        logic [63:0] held;
        exp_t e;
        check("valid_after_last", 65'(valid_o), 65'd1);
        check("ready_low_in_hold", 65'(ready_o), 65'd0);
        held = sum;
        for (int i = 0; i < hold; i++) begin
            ready = 1'b0;
            start = 1'b1;
            len   = 8'd5;
            tick();
            start = 1'b0;
            check("valid_held", 65'(valid_o), 65'd1);
            check("sum_stable", 65'(sum), 65'(held));
        end
        ready = 1'b1;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 65'd0, 65'd1);
        end else begin
            e = sb.pop_front();
            check("sum", 65'(sum), 65'(e.sum));
            check("carry_cnt", 65'(cnt), 65'(e.cnt));
            check("overflow", 65'(ovf), 65'(e.ovf));
        end
        tick();
        ready = 1'b0;
        check("valid_after_hs", 65'(valid_o), 65'd0);
        check("busy_after_hs", 65'(busy), 65'd0);
        check("sum_kept_in_idle", 65'(sum), 65'(held));
    endtask

    initial begin
        tick();
        tick();
        check("rst_sum", 65'(sum), 65'd0);
        check("rst_cnt", 65'(cnt), 65'd0);
        check("rst_ovf", 65'(ovf), 65'd0);
        check("rst_valid", 65'(valid_o), 65'd0);
        check("rst_ready", 65'(ready_o), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of a 4-result burst
        start_burst(8'd4);
        feed(33'd3);
        feed(33'h1_0000_0009);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sum", 65'(sum), 65'd0);
        check("midrst_cnt", 65'(cnt), 65'd0);
        check("midrst_ready", 65'(ready_o), 65'd0);
        check("midrst_busy", 65'(busy), 65'd0);
        check("midrst_valid", 65'(valid_o), 65'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_burst(8'd1);
        feed(33'd5);
        finish_burst();
        drain(0);

        start_burst(8'd3);
        feed(33'h0_0000_0001);
        feed(33'h1_0000_0000);
        feed(33'h1_FFFF_FFFF);
        finish_burst();
        check("spec_sum_3", 65'(sb[0].sum), 65'h3_0000_0000);
        drain(0);

        // valid toggling, then back-pressure with ignored start pulses
        start_burst(8'd4);
        feed(33'h1_2345_6789);
        gap();
        feed(33'h0_FFFF_0000);
        gap();
        feed(33'h1_0000_0001);
        gap();
        feed(33'h0_0000_00AA);
        finish_burst();
        drain(5);

        start_burst(8'd0);
        finish_burst();
        drain(0);

        // back-to-back: start in the cycle right after the handshake
        start_burst(8'd1);
        feed(33'd7);
        finish_burst();
        drain(0);

        // 33-bit accumulator: two maximal results overflow it
        s_start = 1'b1;
        s_len   = 8'd2;
        tick();
        s_start  = 1'b0;
        s_valid  = 1'b1;
        s_result = 33'h1_FFFF_FFFF;
        tick();
        tick();
        s_valid = 1'b0;
        check("acc33_valid", 65'(s_valid_o), 65'd1);
`ifdef ACC_SATURATE_EN
        check("acc33_sum", 65'(s_sum), 65'h1_FFFF_FFFF);
`else
        check("acc33_sum", 65'(s_sum), 65'h1_FFFF_FFFE);
`endif
        check("acc33_ovf", 65'(s_ovf), 65'd1);
        check("acc33_cnt", 65'(s_cnt), 65'd2);
        s_ready = 1'b1;
        tick();
        s_ready  = 1'b0;
        s_start  = 1'b1;
        s_len    = 8'd1;
        tick();
        s_start  = 1'b0;
        s_valid  = 1'b1;
        s_result = 33'd7;
        tick();
        s_valid = 1'b0;
        check("acc33_b2b_sum", 65'(s_sum), 65'd7);
        check("acc33_b2b_ovf", 65'(s_ovf), 65'd0);
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
